// File: rtl/dmux16_stream.sv
// Registered 1-to-2 word demultiplexer with a one-entry valid/ready slot per output.
// Define DMUX16_COUNT_EN to add the 8-bit delivered-word counters a_count/b_count.
module dmux16_stream #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_s,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] a,
   output logic             a_valid,
   input  logic             a_ready,
   output logic [WIDTH-1:0] b,
   output logic             b_valid,
   input  logic             b_ready
`ifdef DMUX16_COUNT_EN
   ,
   output logic [7:0]       a_count,
   output logic [7:0]       b_count
`endif
);

   logic a_free;
   logic b_free;
   logic load_a;
   logic load_b;
   logic take_a;
   logic take_b;

   // A slot can take a word when it is empty or is being emptied this cycle.
   always_comb begin
      a_free   = !a_valid || a_ready;
      b_free   = !b_valid || b_ready;
      in_ready = in_s ? b_free : a_free;
      load_a   = in_valid && in_ready && !in_s;
      load_b   = in_valid && in_ready && in_s;
      take_a   = a_valid && a_ready;
      take_b   = b_valid && b_ready;
   end

   // Load wins over drain, so a same-edge drain and load leaves valid set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a       <= '0;
         a_valid <= 1'b0;
      end else if (load_a) begin
         a       <= in_data;
         a_valid <= 1'b1;
      end else if (take_a) begin
         a_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         b       <= '0;
         b_valid <= 1'b0;
      end else if (load_b) begin
         b       <= in_data;
         b_valid <= 1'b1;
      end else if (take_b) begin
         b_valid <= 1'b0;
      end
   end

`ifdef DMUX16_COUNT_EN
   // Counters wrap naturally at 8 bits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_count <= 8'd0;
         b_count <= 8'd0;
      end else begin
         if (take_a) a_count <= a_count + 8'd1;
         if (take_b) b_count <= b_count + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dmux16_stream.sv
// Scoreboard bench for dmux16_stream: per-port queues filled on accept, drained on delivery.
// Counter checks are compiled in when DMUX16_COUNT_EN is defined.
module tb_dmux16_stream;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] in_data = '0;
   logic        in_s = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] a;
   logic        a_valid;
   logic        a_ready = 1'b0;
   logic [15:0] b;
   logic        b_valid;
   logic        b_ready = 1'b0;
`ifdef DMUX16_COUNT_EN
   logic [7:0]  a_count;
   logic [7:0]  b_count;
`endif

   int checks = 0;
   int errors = 0;

   logic [15:0] qa[$];
   logic [15:0] qb[$];
   logic [15:0] last_a = '0;
   logic [15:0] last_b = '0;
   logic [7:0]  exp_a_cnt = '0;
   logic [7:0]  exp_b_cnt = '0;

   dmux16_stream #(.WIDTH(16)) dut (
      .clk(clk),
      .rst(rst),
      .in_data(in_data),
      .in_s(in_s),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .a(a),
      .a_valid(a_valid),
      .a_ready(a_ready),
      .b(b),
      .b_valid(b_valid),
      .b_ready(b_ready)
`ifdef DMUX16_COUNT_EN
      ,
      .a_count(a_count),
      .b_count(b_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed %h expected %h at %0t", tag, observed, expected, $time);
      end
   endtask

   // One cycle of stimulus, driven just after the rising edge.
   task automatic applyStimulus(input logic [15:0] d, input logic s, input logic v,
                                input logic ar, input logic br);
      @(posedge clk);
      #1;
      in_data  = d;
      in_s     = s;
      in_valid = v;
      a_ready  = ar;
      b_ready  = br;
   endtask

   // Monitor on the falling edge: compare DUT to the model, then advance the model.
   always @(negedge clk) begin
      logic exp_ready;
      logic [15:0] got;
      if (rst) begin
         qa.delete();
         qb.delete();
         last_a    = '0;
         last_b    = '0;
         exp_a_cnt = '0;
         exp_b_cnt = '0;
      end else begin
         exp_ready = in_s ? (qb.size() == 0 || b_ready) : (qa.size() == 0 || a_ready);
         checkOutput("a_valid", {31'd0, a_valid}, {31'd0, qa.size() != 0});
         checkOutput("b_valid", {31'd0, b_valid}, {31'd0, qb.size() != 0});
         checkOutput("a_data", {16'd0, a}, {16'd0, last_a});
         checkOutput("b_data", {16'd0, b}, {16'd0, last_b});
         checkOutput("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
`ifdef DMUX16_COUNT_EN
         checkOutput("a_count", {24'd0, a_count}, {24'd0, exp_a_cnt});
         checkOutput("b_count", {24'd0, b_count}, {24'd0, exp_b_cnt});
`endif
         if (qa.size() != 0 && a_ready) begin
            got = qa.pop_front();
            checkOutput("a_deliver", {16'd0, a}, {16'd0, got});
            exp_a_cnt = exp_a_cnt + 8'd1;
         end
         if (qb.size() != 0 && b_ready) begin
            got = qb.pop_front();
            checkOutput("b_deliver", {16'd0, b}, {16'd0, got});
            exp_b_cnt = exp_b_cnt + 8'd1;
         end
         if (in_valid && exp_ready) begin
            if (in_s) begin
               qb.push_back(in_data);
               last_b = in_data;
            end else begin
               qa.push_back(in_data);
               last_a = in_data;
            end
         end
      end
   end

   initial begin
      $display("[TB] dmux16_stream bench start");
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_a", {16'd0, a}, 32'd0);
      checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
      rst = 1'b0;

      // Route to a, then to b while a drains.
      applyStimulus(16'hAAAA, 1'b0, 1'b1, 1'b1, 1'b1);
      applyStimulus(16'h5555, 1'b1, 1'b1, 1'b1, 1'b1);
      applyStimulus(16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);

      // Stall a, keep offering to a, then send to b past the stall.
      applyStimulus(16'h1234, 1'b0, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++)
         applyStimulus(16'h9999, 1'b0, 1'b1, 1'b0, 1'b1);
      applyStimulus(16'hBEEF, 1'b1, 1'b1, 1'b0, 1'b1);
      applyStimulus(16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);

      // Back-to-back stream into a.
      for (int i = 1; i <= 8; i++)
         applyStimulus(i[15:0], 1'b0, 1'b1, 1'b1, 1'b1);

      // Drain and load on the same edge.
      applyStimulus(16'hCAFE, 1'b0, 1'b1, 1'b1, 1'b1);
      applyStimulus(16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);

      // in_s toggling with in_valid low must load nothing.
      applyStimulus(16'hDEAD, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(16'hDEAD, 1'b0, 1'b0, 1'b0, 1'b0);

      // Asynchronous reset with a word held in a.
      applyStimulus(16'h7777, 1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("async_a", {16'd0, a}, 32'd0);
      checkOutput("async_a_valid", {31'd0, a_valid}, 32'd0);
      checkOutput("async_b_valid", {31'd0, b_valid}, 32'd0);
      checkOutput("async_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Random traffic with random backpressure.
      for (int i = 0; i < 300; i++)
         applyStimulus(16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0),
                       1'($urandom_range(0, 3) != 0));
      for (int i = 0; i < 3; i++)
         applyStimulus(16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);

`ifdef DMUX16_COUNT_EN
      // Counter wrap: 257 words to b after a fresh reset.
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 257; i++)
         applyStimulus(16'(i), 1'b1, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++)
         applyStimulus(16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      checkOutput("b_count_wrap", {24'd0, b_count}, 32'd1);
      checkOutput("a_count_zero", {24'd0, a_count}, 32'd0);
`endif

      @(negedge clk);
      #1;
      checkOutput("qa_empty", qa.size(), 32'd0);
      checkOutput("qb_empty", qb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmux16_stream.md
# dmux16_stream

Registered 1-to-2 word demultiplexer. It is the inverse of the 16-bit two-input word multiplexer: one input word stream is steered by a select bit to one of two output streams. Each output has a one-entry holding register with valid/ready flow control. It sits between a single word producer (ALU/CPU datapath) and two consumers (e.g. memory path and register path).

## Interface
Parameters:
- WIDTH, 16, data word width in bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous, active-high; clears all state.
- in_data  input  WIDTH  word to route.
- in_s  input  1  select; 0 routes to port a, 1 routes to port b.
- in_valid  input  1  in_data/in_s are valid this cycle.
- in_ready  output  1  combinational; the word presented this cycle is accepted at the next edge.
- a  output  WIDTH  port a data, registered.
- a_valid  output  1  port a holds a word.
- a_ready  input  1  port a consumer takes the word this cycle.
- b  output  WIDTH  port b data, registered.
- b_valid  output  1  port b holds a word.
- b_ready  input  1  port b consumer takes the word this cycle.
- a_count, b_count  output  8  delivered-word counters; present only with DMUX16_COUNT_EN.

## Operation
- Reset values: a=0, b=0, a_valid=0, b_valid=0, a_count=0, b_count=0. in_ready follows from the reset state, so it is 1.
- Accept rule:
  - in_ready = in_s ? (!b_valid | b_ready) : (!a_valid | a_ready).
  - in_ready depends only on the selected slot. It never depends on in_valid.
- Load: when in_valid & in_ready, the selected slot (a or b) captures in_data at the edge and its valid bit becomes 1.
- Drain: a slot with valid=1 and ready=1 and no load this edge clears valid. The data register keeps its last value.
- Drain and load in the same edge on the same slot: the new word is loaded and valid stays 1. There is no bubble.
- The unselected slot is unaffected by the input handshake. It drains independently.
- Both slots may drain in the same cycle.
- Stall: while valid=1 and ready=0, the slot's data and valid are held stable. New words for that slot are refused (in_ready=0).
- Words to different ports may be accepted while the other port is stalled. There is no head-of-line blocking across ports.
- Per-port order is preserved. Cross-port order is not defined.
- in_s is sampled only when in_valid=1. When in_valid=0, in_s is ignored and nothing loads.
- rst asserted mid-operation: buffered words are discarded immediately, without waiting for a clock edge, and all outputs go to their reset values.

## Timing
- Latency: 1 cycle. A word accepted at edge N is visible on a/b with valid=1 after edge N.
- Throughput: 1 word/cycle per port when the consumer holds ready=1.
- No combinational path from in_data to a/b.
- in_ready has combinational paths from in_s, a_ready and b_ready.
- Outputs change only on clk rising edges or on rst assertion.

## Configuration
- DMUX16_COUNT_EN defined:
  - a_count/b_count exist.
  - Each increments by 1 on its port's output handshake (valid & ready).
  - Each is 8 bits and wraps from 255 to 0.
  - Both are cleared by rst.
  - They do not affect data path timing.
- DMUX16_COUNT_EN undefined: counter ports and logic are absent. All other behaviour is identical.

## Test plan
- Reset: assert rst mid-cycle with a_valid=1 -> a=0, a_valid=0, b_valid=0 immediately; in_ready=1.
- Route: in_data=16'hAAAA, in_s=0, in_valid=1, a_ready=1 -> after 1 edge a=16'hAAAA, a_valid=1, b_valid=0. Then in_data=16'h5555, in_s=1 -> b=16'h5555, b_valid=1; a drains.
- Stall: a_ready=0, a holds 16'h1234; present in_s=0 -> in_ready=0, a stays 16'h1234 for 5 cycles. Present in_s=1, 16'hBEEF -> accepted, b=16'hBEEF.
- Back-to-back: a_ready=1, stream 16'h0001..16'h0008 with in_s=0 every cycle -> a shows each value one cycle after acceptance, a_valid continuously 1, no bubbles.
- Simultaneous drain and load: a_valid=1, a_ready=1, new word 16'hCAFE to a in the same cycle -> a=16'hCAFE, a_valid stays 1.
- With DMUX16_COUNT_EN: deliver 257 words to port b -> b_count=1 (wrapped), a_count=0.
